// File: rtl/icap_seq_pkg.sv
// Shared types and constants for the ICAPE2 register-access sequencer.
// Holds the FSM state encoding, the configuration packet words and the byte bit-reversal helper.
package icap_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_SEQ,
        RD_TURN_IN,
        RD_DATA,
        RD_TURN_OUT,
        DESYNC,
        DONE
    } state_e;

    localparam logic [31:0] DUMMY       = 32'hFFFF_FFFF;
    localparam logic [31:0] SYNC        = 32'hAA99_5566;
    localparam logic [31:0] NOOP        = 32'h2000_0000;
    localparam logic [31:0] WR_HDR_BASE = 32'h3000_0001;
    localparam logic [31:0] RD_HDR_BASE = 32'h2800_0001;
    localparam logic [31:0] DESYNC_HDR  = 32'h3000_8001;
    localparam logic [31:0] DESYNC_CMD  = 32'h0000_000D;

    // Last word index of the header phase for each direction, and of the desync phase.
    localparam logic [3:0] WR_HDR_LAST = 4'd6;
    localparam logic [3:0] RD_HDR_LAST = 4'd5;
    localparam logic [3:0] DESYNC_LAST = 4'd3;

    // ICAPE2 expects each byte with its bit order mirrored relative to the bitstream word.
    function automatic logic [31:0] bitrev_bytes(input logic [31:0] w);
        logic [31:0] r;
        r = '0;
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 8; i++) begin
                r[8*b+i] = w[8*b+7-i];
            end
        end
        return r;
    endfunction

    // Type-1 packet header with the register address placed in bits 17:13.
    function automatic logic [31:0] hdr_word(input logic [31:0] base, input logic [4:0] addr);
        return base | {14'd0, addr, 13'd0};
    endfunction

endpackage

// File: rtl/icap_seq_arb.sv
// Two-way round-robin arbiter: the requester named by ptr_i wins a tie.
// Pure combinational; the caller owns the pointer register.
module icap_seq_arb (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        if (req_i[ptr_i]) begin
            gnt_o[ptr_i] = 1'b1;
        end else if (req_i[~ptr_i]) begin
            gnt_o[~ptr_i] = 1'b1;
        end
    end

endmodule

// File: rtl/icap_seq.sv
// Sequencer that turns single register read/write requests from two clients
// into complete ICAPE2 packet sequences (sync, header, data, desync).
module icap_seq
    import icap_seq_pkg::*;
#(
    parameter int unsigned READ_LAT  = 3,
    parameter logic [31:0] IDLE_WORD = 32'hFFFF_FFFF
) (
    input  logic        CLK,
    input  logic        RSTB,
    input  logic [1:0]  REQ,
    input  logic [1:0]  REQ_WR,
    input  logic [4:0]  REQ_ADDR0,
    input  logic [4:0]  REQ_ADDR1,
    input  logic [31:0] REQ_WDATA0,
    input  logic [31:0] REQ_WDATA1,
    output logic [1:0]  ACK,
    output logic [31:0] RDATA,
    output logic        BUSY,
    output logic        ICAP_CSIB,
    output logic        ICAP_RDWRB,
    output logic [31:0] ICAP_I,
    input  logic [31:0] ICAP_O
);

    localparam logic [3:0] LAT_LAST = 4'(READ_LAT - 1);

    state_e      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic        ptr_q;
    logic [1:0]  gnt_q;
    logic        wr_q;
    logic [4:0]  addr_q;
    logic [31:0] wdata_q;
    logic [31:0] sample_q;

    logic        csib_q, csib_d;
    logic        rdwrb_q, rdwrb_d;
    logic [31:0] icap_i_q, icap_i_d;
    logic [1:0]  ack_q;
    logic        busy_q;
    logic [31:0] rdata_q;

    logic [1:0]  gnt;
    logic        grant_now;
    logic [31:0] hdr_d;
    logic [31:0] seq_word_d;
    logic [31:0] desync_word_d;

    icap_seq_arb u_arb (
        .req_i (REQ),
        .ptr_i (ptr_q),
        .gnt_o (gnt)
    );

    assign grant_now = (state_q == IDLE) && (|REQ);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (|REQ) begin
                    state_d = WR_SEQ;
                    idx_d   = '0;
                end
            end
            WR_SEQ: begin
                if (idx_q == (wr_q ? WR_HDR_LAST : RD_HDR_LAST)) begin
                    state_d = wr_q ? DESYNC : RD_TURN_IN;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            RD_TURN_IN: begin
                if (idx_q == 4'd1) begin
                    state_d = RD_DATA;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            RD_DATA: begin
                if (idx_q == LAT_LAST) begin
                    state_d = RD_TURN_OUT;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            RD_TURN_OUT: begin
                if (idx_q == 4'd1) begin
                    state_d = DESYNC;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            DESYNC: begin
                if (idx_q == DESYNC_LAST) begin
                    state_d = DONE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                idx_d   = '0;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Word tables are indexed by the next index so the ICAP pins come straight from flops.
    always_comb begin
        hdr_d = hdr_word(wr_q ? WR_HDR_BASE : RD_HDR_BASE, addr_q);
        case (idx_d)
            4'd0:    seq_word_d = DUMMY;
            4'd1:    seq_word_d = SYNC;
            4'd2:    seq_word_d = NOOP;
            4'd3:    seq_word_d = hdr_d;
            4'd4:    seq_word_d = wr_q ? wdata_q : NOOP;
            default: seq_word_d = NOOP;
        endcase
        case (idx_d)
            4'd0:    desync_word_d = DESYNC_HDR;
            4'd1:    desync_word_d = DESYNC_CMD;
            default: desync_word_d = NOOP;
        endcase
    end

    // Turnaround cycles keep CSIB high so RDWRB only ever moves while deselected.
    always_comb begin
        csib_d   = 1'b1;
        rdwrb_d  = 1'b0;
        icap_i_d = IDLE_WORD;
        case (state_d)
            WR_SEQ: begin
                csib_d   = 1'b0;
                icap_i_d = bitrev_bytes(seq_word_d);
            end
            DESYNC: begin
                csib_d   = 1'b0;
                icap_i_d = bitrev_bytes(desync_word_d);
            end
            RD_TURN_IN:  rdwrb_d = (idx_d == 4'd1);
            RD_DATA: begin
                csib_d  = 1'b0;
                rdwrb_d = 1'b1;
            end
            RD_TURN_OUT: rdwrb_d = (idx_d == 4'd0);
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            ptr_q    <= 1'b0;
            gnt_q    <= '0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            sample_q <= '0;
            csib_q   <= 1'b1;
            rdwrb_q  <= 1'b0;
            icap_i_q <= IDLE_WORD;
            ack_q    <= '0;
            busy_q   <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            csib_q   <= csib_d;
            rdwrb_q  <= rdwrb_d;
            icap_i_q <= icap_i_d;
            busy_q   <= (state_d != IDLE);
            ack_q    <= (state_d == DONE) ? gnt_q : 2'b00;
            if (grant_now) begin
                gnt_q   <= gnt;
                ptr_q   <= gnt[0];
                wr_q    <= |(REQ_WR & gnt);
                addr_q  <= gnt[1] ? REQ_ADDR1 : REQ_ADDR0;
                wdata_q <= gnt[1] ? REQ_WDATA1 : REQ_WDATA0;
            end
            if (state_q == RD_DATA && idx_q == LAT_LAST) begin
                sample_q <= ICAP_O;
            end
            if (state_d == DONE && !wr_q) begin
                rdata_q <= bitrev_bytes(sample_q);
            end
        end
    end

    assign ICAP_CSIB  = csib_q;
    assign ICAP_RDWRB = rdwrb_q;
    assign ICAP_I     = icap_i_q;
    assign ACK        = ack_q;
    assign BUSY       = busy_q;
    assign RDATA      = rdata_q;

endmodule
